// File: rtl/rv_pkg.sv
// Shared constants and types for the writeback slice: datapath width,
// register-file geometry and the load funct3 encodings.
package rv_pkg;

    localparam int XLEN       = 32;
    localparam int NREG       = 32;
    localparam int REG_ADDR_W = 5;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // One pending register-file write: destination index plus data
    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [XLEN-1:0]       data;
    } wbEntry_t;

endpackage

// File: rtl/load_ext.sv
// Load extension: picks the addressed byte/half lane out of the aligned
// memory word and sign- or zero-extends it to the full datapath width.
module load_ext
    import rv_pkg::*;
(
    input  logic [2:0]      i_funct3,
    input  logic [1:0]      i_byteOff,
    input  logic [XLEN-1:0] i_word,
    output logic [XLEN-1:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Select the byte lane named by the low address bits
    always_comb begin
        case (i_byteOff)
            2'd0:    w_byte = i_word[7:0];
            2'd1:    w_byte = i_word[15:8];
            2'd2:    w_byte = i_word[23:16];
            default: w_byte = i_word[31:24];
        endcase
    end

    assign w_half = i_byteOff[1] ? i_word[31:16] : i_word[15:0];

    // Extend according to the load type; unknown encodings pass the raw word
    always_comb begin
        case (i_funct3)
            F3_LB:   o_data = {{(XLEN-8){w_byte[7]}}, w_byte};
            F3_LH:   o_data = {{(XLEN-16){w_half[15]}}, w_half};
            F3_LBU:  o_data = {{(XLEN-8){1'b0}}, w_byte};
            F3_LHU:  o_data = {{(XLEN-16){1'b0}}, w_half};
            F3_LW:   o_data = i_word;
            default: o_data = i_word;
        endcase
    end

endmodule

// File: rtl/writeback_unit.sv
// Writeback stage: merges ALU results and returning loads into one registered
// register-file write port, parks a colliding ALU result in a one-entry hold
// register, and keeps the busy scoreboard that stalls decode on hazards.
module writeback_unit
    import rv_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  dec_valid,
    input  logic [REG_ADDR_W-1:0] dec_rs1_addr,
    input  logic [REG_ADDR_W-1:0] dec_rs2_addr,
    input  logic [REG_ADDR_W-1:0] dec_rd_addr,
    output logic                  dec_stall,
    input  logic                  alu_valid,
    input  logic [REG_ADDR_W-1:0] alu_rd_addr,
    input  logic [XLEN-1:0]       alu_data,
    output logic                  alu_ready,
    input  logic                  mem_valid,
    input  logic [REG_ADDR_W-1:0] mem_rd_addr,
    input  logic [2:0]            mem_funct3,
    input  logic [1:0]            mem_byte_off,
    input  logic [XLEN-1:0]       mem_data,
    output logic                  rd_w,
    output logic [REG_ADDR_W-1:0] rd_addr,
    output logic [XLEN-1:0]       rd,
    output logic [NREG-1:0]       busy
);

    logic                  r_holdValid;
    wbEntry_t              r_hold;
    logic                  r_rdW;
    logic [REG_ADDR_W-1:0] r_rdAddr;
    logic [XLEN-1:0]       r_rd;
    logic [NREG-1:0]       r_busy;

    logic [XLEN-1:0]       w_loadData;
    logic                  w_aluAccept;
    logic                  w_selValid;
    wbEntry_t              w_sel;
    logic                  w_holdLoad;
    logic                  w_holdClear;
    logic                  w_writeEn;
    logic                  w_issue;
    logic [NREG-1:0]       w_busyNext;

    load_ext u_loadExt (
        .i_funct3  (mem_funct3),
        .i_byteOff (mem_byte_off),
        .i_word    (mem_data),
        .o_data    (w_loadData)
    );

    assign alu_ready   = !r_holdValid || !mem_valid;
    assign w_aluAccept = alu_valid && alu_ready;

    assign dec_stall = dec_valid && (r_busy[dec_rs1_addr] || r_busy[dec_rs2_addr] || r_busy[dec_rd_addr]);
    assign w_issue   = dec_valid && !dec_stall && (dec_rd_addr != '0);

    // Pick this cycle's write: load first, then the parked ALU result, then a fresh ALU result
    always_comb begin
        w_selValid  = 1'b0;
        w_sel       = '0;
        w_holdLoad  = 1'b0;
        w_holdClear = 1'b0;
        if (mem_valid) begin
            w_selValid = 1'b1;
            w_sel      = {mem_rd_addr, w_loadData};
            w_holdLoad = w_aluAccept;
        end else if (r_holdValid) begin
            w_selValid  = 1'b1;
            w_sel       = r_hold;
            w_holdLoad  = w_aluAccept;
            w_holdClear = !w_aluAccept;
        end else if (w_aluAccept) begin
            w_selValid = 1'b1;
            w_sel      = {alu_rd_addr, alu_data};
        end
    end

    assign w_writeEn = w_selValid && (w_sel.addr != '0);

    // Retire the write being registered and mark new destinations; a same-cycle set beats the clear
    always_comb begin
        w_busyNext = r_busy;
        if (w_writeEn) begin
            w_busyNext[w_sel.addr] = 1'b0;
        end
        if (w_issue) begin
            w_busyNext[dec_rd_addr] = 1'b1;
        end
        w_busyNext[0] = 1'b0;
    end

    // One-entry hold register for an ALU result displaced by a load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_holdValid <= 1'b0;
            r_hold      <= '0;
        end else if (w_holdLoad) begin
            r_holdValid <= 1'b1;
            r_hold      <= {alu_rd_addr, alu_data};
        end else if (w_holdClear) begin
            r_holdValid <= 1'b0;
        end
    end

    // Register the selected write; index and data only move when a real write happens
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdW    <= 1'b0;
            r_rdAddr <= '0;
            r_rd     <= '0;
        end else begin
            r_rdW <= w_writeEn;
            if (w_writeEn) begin
                r_rdAddr <= w_sel.addr;
                r_rd     <= w_sel.data;
            end
        end
    end

    // Busy scoreboard state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busyNext;
        end
    end

    assign rd_w    = r_rdW;
    assign rd_addr = r_rdAddr;
    assign rd      = r_rd;
    assign busy    = r_busy;

endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// queue-based behavioural model of the writeback rules.
module tb_writeback_unit;

    logic        clk;
    logic        rst_n;
    logic        dec_valid;
    logic [4:0]  dec_rs1_addr;
    logic [4:0]  dec_rs2_addr;
    logic [4:0]  dec_rd_addr;
    logic        dec_stall;
    logic        alu_valid;
    logic [4:0]  alu_rd_addr;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        mem_valid;
    logic [4:0]  mem_rd_addr;
    logic [2:0]  mem_funct3;
    logic [1:0]  mem_byte_off;
    logic [31:0] mem_data;
    logic        rd_w;
    logic [4:0]  rd_addr;
    logic [31:0] rd;
    logic [31:0] busy;

    writeback_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .dec_valid    (dec_valid),
        .dec_rs1_addr (dec_rs1_addr),
        .dec_rs2_addr (dec_rs2_addr),
        .dec_rd_addr  (dec_rd_addr),
        .dec_stall    (dec_stall),
        .alu_valid    (alu_valid),
        .alu_rd_addr  (alu_rd_addr),
        .alu_data     (alu_data),
        .alu_ready    (alu_ready),
        .mem_valid    (mem_valid),
        .mem_rd_addr  (mem_rd_addr),
        .mem_funct3   (mem_funct3),
        .mem_byte_off (mem_byte_off),
        .mem_data     (mem_data),
        .rd_w         (rd_w),
        .rd_addr      (rd_addr),
        .rd           (rd),
        .busy         (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checkCount = 0;
    int errorCount = 0;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } pend_t;

    // Behavioural model state
    pend_t       pendQ[$];
    logic [31:0] mBusy   = '0;
    bit          expRdW  = 1'b0;
    logic [4:0]  expAddr = '0;
    logic [31:0] expRd   = '0;
    bit          aluTaken = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Load result from the ISA rules using shifts and masks
    function automatic logic [31:0] loadModel(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] w);
        logic [31:0] b;
        logic [31:0] h;
        b = (w >> (8 * off)) & 32'h0000_00FF;
        h = (w >> (16 * off[1])) & 32'h0000_FFFF;
        case (f3)
            3'b000:  return (b >= 32'd128) ? b - 32'd256 : b;
            3'b001:  return (h >= 32'd32768) ? h - 32'd65536 : h;
            3'b100:  return b;
            3'b101:  return h;
            default: return w;
        endcase
    endfunction

    // Model: advance one clock using the inputs presented during the cycle
    initial begin
        bit    mReady;
        bit    mStall;
        bit    wv;
        pend_t w;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                pendQ.delete();
                mBusy    = '0;
                expRdW   = 1'b0;
                expAddr  = '0;
                expRd    = '0;
                aluTaken = 1'b0;
            end else begin
                mReady   = !(pendQ.size() != 0 && mem_valid);
                aluTaken = alu_valid && mReady;
                mStall   = dec_valid && (mBusy[dec_rs1_addr] || mBusy[dec_rs2_addr] || mBusy[dec_rd_addr]);
                wv = 1'b0;
                w  = '{addr: 5'd0, data: 32'd0};
                if (mem_valid) begin
                    wv = 1'b1;
                    w  = '{addr: mem_rd_addr, data: loadModel(mem_funct3, mem_byte_off, mem_data)};
                    if (aluTaken) pendQ.push_back('{addr: alu_rd_addr, data: alu_data});
                end else if (pendQ.size() != 0) begin
                    wv = 1'b1;
                    w  = pendQ.pop_front();
                    if (aluTaken) pendQ.push_back('{addr: alu_rd_addr, data: alu_data});
                end else if (aluTaken) begin
                    wv = 1'b1;
                    w  = '{addr: alu_rd_addr, data: alu_data};
                end
                expRdW = wv && (w.addr != 5'd0);
                if (expRdW) begin
                    expAddr = w.addr;
                    expRd   = w.data;
                    mBusy[w.addr] = 1'b0;
                end
                if (dec_valid && !mStall && dec_rd_addr != 5'd0) mBusy[dec_rd_addr] = 1'b1;
            end
        end
    end

    // Compare process: every cycle out of reset, DUT outputs against the model
    initial begin
        bit expReady;
        bit expStall;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                expReady = !(pendQ.size() != 0 && mem_valid);
                expStall = dec_valid && (mBusy[dec_rs1_addr] || mBusy[dec_rs2_addr] || mBusy[dec_rd_addr]);
                checkOutput("model rd_w", {31'd0, rd_w}, {31'd0, expRdW});
                if (expRdW) begin
                    checkOutput("model rd_addr", {27'd0, rd_addr}, {27'd0, expAddr});
                    checkOutput("model rd", rd, expRd);
                end
                checkOutput("model busy", busy, mBusy);
                checkOutput("model alu_ready", {31'd0, alu_ready}, {31'd0, expReady});
                checkOutput("model dec_stall", {31'd0, dec_stall}, {31'd0, expStall});
            end
        end
    end

    task automatic applyStimulus(
        input logic dv, input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rdA,
        input logic av, input logic [4:0] aa, input logic [31:0] ad,
        input logic mv, input logic [4:0] ma, input logic [2:0] f3, input logic [1:0] off, input logic [31:0] md);
        dec_valid    = dv;
        dec_rs1_addr = rs1;
        dec_rs2_addr = rs2;
        dec_rd_addr  = rdA;
        alu_valid    = av;
        alu_rd_addr  = aa;
        alu_data     = ad;
        mem_valid    = mv;
        mem_rd_addr  = ma;
        mem_funct3   = f3;
        mem_byte_off = off;
        mem_data     = md;
    endtask

    task automatic applyIdle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [4:0] randAddr();
        if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
        return 5'($urandom_range(0, 7));
    endfunction

    initial begin
        logic        nav;
        logic [4:0]  naa;
        logic [31:0] nad;

        rst_n = 1'b1;
        applyIdle();
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2;

        // Model pins from hand-worked load examples
        checkOutput("pin LB", loadModel(3'b000, 2'd1, 32'h0000_8000), 32'hFFFF_FF80);
        checkOutput("pin LHU", loadModel(3'b101, 2'd2, 32'h8000_1234), 32'h0000_8000);

        // Reset state
        checkOutput("reset rd_w", {31'd0, rd_w}, 32'd0);
        checkOutput("reset rd_addr", {27'd0, rd_addr}, 32'd0);
        checkOutput("reset rd", rd, 32'd0);
        checkOutput("reset busy", busy, 32'd0);
        checkOutput("reset alu_ready", {31'd0, alu_ready}, 32'd1);
        rst_n = 1'b1;

        // Lone ALU write
        applyStimulus(0, 0, 0, 0, 1, 5'd5, 32'h1234, 0, 0, 0, 0, 0);
        tick();
        checkOutput("alu rd_w", {31'd0, rd_w}, 32'd1);
        checkOutput("alu rd_addr", {27'd0, rd_addr}, 32'd5);
        checkOutput("alu rd", rd, 32'h1234);
        applyIdle();
        tick();
        checkOutput("alu rd_w drop", {31'd0, rd_w}, 32'd0);

        // Load extension
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 5'd7, 3'b000, 2'd1, 32'h0000_8000);
        tick();
        checkOutput("LB rd_addr", {27'd0, rd_addr}, 32'd7);
        checkOutput("LB rd", rd, 32'hFFFF_FF80);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 5'd7, 3'b100, 2'd1, 32'h0000_8000);
        tick();
        checkOutput("LBU rd", rd, 32'h0000_0080);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 5'd7, 3'b001, 2'd2, 32'h8000_0000);
        tick();
        checkOutput("LH rd", rd, 32'hFFFF_8000);

        // Load and ALU in the same cycle
        applyStimulus(0, 0, 0, 0, 1, 5'd4, 32'h44, 1, 5'd3, 3'b010, 2'd3, 32'hAAAA_5555);
        #1;
        checkOutput("collide alu_ready", {31'd0, alu_ready}, 32'd1);
        tick();
        checkOutput("collide first addr", {27'd0, rd_addr}, 32'd3);
        checkOutput("collide first rd", rd, 32'hAAAA_5555);
        applyIdle();
        tick();
        checkOutput("collide second rd_w", {31'd0, rd_w}, 32'd1);
        checkOutput("collide second addr", {27'd0, rd_addr}, 32'd4);
        checkOutput("collide second rd", rd, 32'h44);

        // RAW hazard on x9
        applyStimulus(1, 5'd1, 5'd2, 5'd9, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        checkOutput("issue x9 stall", {31'd0, dec_stall}, 32'd0);
        tick();
        checkOutput("busy9 set", {31'd0, busy[9]}, 32'd1);
        applyStimulus(1, 5'd9, 5'd0, 5'd10, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        checkOutput("raw stall", {31'd0, dec_stall}, 32'd1);
        tick();
        checkOutput("raw stall held", {31'd0, dec_stall}, 32'd1);
        applyStimulus(1, 5'd9, 5'd0, 5'd10, 1, 5'd9, 32'h99, 0, 0, 0, 0, 0);
        tick();
        checkOutput("retire addr", {27'd0, rd_addr}, 32'd9);
        checkOutput("busy9 clear", {31'd0, busy[9]}, 32'd0);
        checkOutput("raw stall released", {31'd0, dec_stall}, 32'd0);
        applyIdle();
        tick();

        // x0 destination and sources
        applyStimulus(1, 5'd0, 5'd0, 5'd0, 1, 5'd0, 32'hDEAD, 0, 0, 0, 0, 0);
        #1;
        checkOutput("x0 stall", {31'd0, dec_stall}, 32'd0);
        tick();
        checkOutput("x0 rd_w", {31'd0, rd_w}, 32'd0);
        checkOutput("x0 busy", busy, 32'd0);
        applyIdle();
        tick();

        // Asynchronous reset with hold full and a busy register
        applyStimulus(1, 5'd1, 5'd2, 5'd12, 1, 5'd4, 32'h4444, 1, 5'd3, 3'b010, 2'd0, 32'h3333);
        tick();
        checkOutput("pre-reset busy12", {31'd0, busy[12]}, 32'd1);
        applyStimulus(0, 0, 0, 0, 1, 5'd6, 32'h6666, 1, 5'd5, 3'b010, 2'd0, 32'h5555);
        #1;
        checkOutput("hold full alu_ready", {31'd0, alu_ready}, 32'd0);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("async rd_w", {31'd0, rd_w}, 32'd0);
        checkOutput("async rd_addr", {27'd0, rd_addr}, 32'd0);
        checkOutput("async rd", rd, 32'd0);
        checkOutput("async busy", busy, 32'd0);
        checkOutput("async alu_ready", {31'd0, alu_ready}, 32'd1);
        applyIdle();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        checkOutput("post-reset rd_w", {31'd0, rd_w}, 32'd0);
        tick();
        checkOutput("post-reset rd_w 2", {31'd0, rd_w}, 32'd0);

        // Randomized traffic; the ALU keeps its result until it is taken
        for (int c = 0; c < 3000; c++) begin
            if (!alu_valid || aluTaken) begin
                nav = ($urandom_range(0, 1) == 1);
                naa = randAddr();
                nad = $urandom;
            end else begin
                nav = alu_valid;
                naa = alu_rd_addr;
                nad = alu_data;
            end
            applyStimulus($urandom_range(0, 2) != 0, randAddr(), randAddr(), randAddr(),
                          nav, naa, nad,
                          $urandom_range(0, 2) == 0, randAddr(), 3'($urandom_range(0, 7)),
                          2'($urandom_range(0, 3)), $urandom);
            tick();
        end
        applyIdle();
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
